// File: rtl/decode_ctrl.sv
// decode_ctrl: ID-stage controller holding the IF/ID register, opcode decode, valid/ready, load-use bubble and flush.
// Optional sticky illegal-opcode trap enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_ctrl #(
    parameter int PC_W = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic [1:0]      Imm_sel,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            alu_src,
    output logic            illegal,
    output logic            hazard_stall
);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t          state_q, state_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic [6:0]      op, if_op;
    logic [4:0]      rd;
    logic            adv, hazard, xfer, rs2_used;

    assign op       = id_instr_q[6:0];
    assign if_op    = if_instr[6:0];
    assign rd       = id_instr_q[11:7];
    assign id_valid = id_valid_q;
    assign id_instr = id_instr_q;
    assign id_pc    = id_pc_q;

    always_comb begin
        Imm_sel   = 2'b11;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        alu_src   = 1'b0;
        if (id_valid_q) begin
            case (op)
                OP_R: reg_write = 1'b1;
                OP_I: {Imm_sel, reg_write, alu_src} = {2'b00, 1'b1, 1'b1};
                OP_L: {Imm_sel, reg_write, mem_read, alu_src} = {2'b00, 1'b1, 1'b1, 1'b1};
                OP_S: {Imm_sel, mem_write, alu_src} = {2'b01, 1'b1, 1'b1};
                OP_B: {Imm_sel, branch} = {2'b10, 1'b1};
                default: Imm_sel = 2'b11;
            endcase
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, bad_op;
    assign bad_op  = id_valid_q & !(op inside {OP_R, OP_I, OP_L, OP_S, OP_B});
    assign illegal = illegal_q | bad_op;
    always_ff @(posedge clk)
        if (rst) illegal_q <= 1'b0;
        else     illegal_q <= !flush & illegal;
`else
    assign illegal = 1'b0;
`endif

    // rs2 only matters for formats that actually read it
    assign rs2_used = if_op inside {OP_R, OP_S, OP_B};
    assign hazard   = id_valid_q & mem_read & (rd != 5'd0) & if_valid &
                      ((if_instr[19:15] == rd) | ((if_instr[24:20] == rd) & rs2_used));
    assign adv      = !id_valid_q | ex_ready;
    assign xfer     = if_valid & if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            id_valid_q <= 1'b0;
            id_instr_q <= XLEN'(32'h0000_0013);
            id_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
        end
    end

    always_comb begin
        state_d    = flush ? RUN : (state_q == RUN && hazard && ex_ready) ? BUBBLE : RUN;
        id_valid_d = flush ? 1'b0 : (adv & !illegal) ? xfer : id_valid_q;
        id_instr_d = xfer ? if_instr : id_instr_q;
        id_pc_d    = xfer ? if_pc : id_pc_q;
    end

    always_comb begin
        if_ready     = adv & (state_q == RUN) & !hazard & !flush & !illegal;
        hazard_stall = (state_q == RUN) & hazard & ex_ready & !flush;
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: scoreboard bench for decode_ctrl; trap checks follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_ctrl;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] SW   = 32'h0020_A023;
    localparam logic [31:0] BEQ  = 32'h0020_8063;
    localparam logic [31:0] LW5  = 32'h0000_A283;
    localparam logic [31:0] LW0  = 32'h0000_A003;
    localparam logic [31:0] ADD  = 32'h0012_8333;
    localparam logic [31:0] BAD  = 32'h0000_007F;

    logic        clk = 1'b0, rst = 1'b1, if_valid = 1'b0, ex_ready = 1'b1, flush = 1'b0;
    logic [31:0] if_instr = 32'h13, if_pc = '0;
    logic        if_ready, id_valid, reg_write, mem_read, mem_write, branch, alu_src, illegal, hazard_stall;
    logic [31:0] id_instr, id_pc;
    logic [1:0]  Imm_sel;
    int          checks = 0, failures = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    decode_ctrl #(.PC_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(if_ready), .ex_ready(ex_ready), .flush(flush), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .Imm_sel(Imm_sel), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .alu_src(alu_src),
        .illegal(illegal), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] exp_imm(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011: return 2'b00;
            7'b0100011:             return 2'b01;
            7'b1100011:             return 2'b10;
            default:                return 2'b11;
        endcase
    endfunction

    // {reg_write, mem_read, mem_write, branch, alu_src}
    function automatic logic [4:0] exp_ctrl(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return 5'b10000;
            7'b0010011: return 5'b10001;
            7'b0000011: return 5'b11001;
            7'b0100011: return 5'b00101;
            7'b1100011: return 5'b00010;
            default:    return 5'b00000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        tick(); tick(); settle();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin failures++; $display("FAIL reset_id_instr got=%h exp=00000013", id_instr); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
        checks++; if (Imm_sel !== 2'b11) begin failures++; $display("FAIL reset_imm_sel got=%b exp=11", Imm_sel); end
        checks++; if ({reg_write, mem_read, mem_write, branch, alu_src} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {reg_write, mem_read, mem_write, branch, alu_src}); end
        checks++; if ({hazard_stall, illegal} !== 2'b00) begin failures++; $display("FAIL reset_stall_illegal got=%b exp=00", {hazard_stall, illegal}); end
        tick(); rst = 1'b0; settle();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
        sb.delete();
    endtask

    task automatic test_stream();
        logic [31:0] prog [3];
        prog = '{ADDI, SW, BEQ};
        for (int i = 0; i < 4; i++) begin
            tick();
            if_valid = (i < 3);
            if (i < 3) begin if_instr = prog[i]; if_pc = 32'h100 + 32'(4 * i); end
            settle();
            if (i > 0) begin
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL stream_sb_empty got=0 exp=1"); end
                else begin
                    exp_e = sb.pop_front();
                    if (id_valid !== 1'b1 || id_instr !== exp_e[31:0] || id_pc !== exp_e[63:32] || Imm_sel !== exp_imm(exp_e[31:0]) ||
                        {reg_write, mem_read, mem_write, branch, alu_src} !== exp_ctrl(exp_e[31:0])) begin
                        failures++;
                        $display("FAIL stream_id_%0d got=%0b/%h/%h/%b/%b exp=1/%h/%h/%b/%b", i, id_valid, id_instr, id_pc, Imm_sel,
                                 {reg_write, mem_read, mem_write, branch, alu_src}, exp_e[31:0], exp_e[63:32], exp_imm(exp_e[31:0]), exp_ctrl(exp_e[31:0]));
                    end
                end
            end
            if (i < 3) begin
                checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL stream_if_ready_%0d got=%0b exp=1", i, if_ready); end
                sb.push_back({if_pc, if_instr});
            end
        end
        tick(); settle();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%0b exp=0", id_valid); end
    endtask

    task automatic test_hazard();
        tick(); if_valid = 1'b1; if_instr = LW5; if_pc = 32'h200; settle();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL hz_accept_lw got=%0b exp=1", if_ready); end
        sb.push_back({if_pc, if_instr});
        tick(); if_instr = ADD; if_pc = 32'h204; settle();
        exp_e = sb.pop_front();
        checks++; if (id_instr !== exp_e[31:0] || mem_read !== 1'b1) begin failures++; $display("FAIL hz_lw_in_id got=%h/%0b exp=%h/1", id_instr, mem_read, exp_e[31:0]); end
        checks++; if (hazard_stall !== 1'b1 || if_ready !== 1'b0) begin failures++; $display("FAIL hz_stall got=%0b/%0b exp=1/0", hazard_stall, if_ready); end
        tick(); settle();
        checks++; if (id_valid !== 1'b0 || hazard_stall !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL hz_bubble got=%0b/%0b/%0b exp=0/0/0", id_valid, hazard_stall, if_ready); end
        tick(); settle();
        checks++; if (id_valid !== 1'b0 || hazard_stall !== 1'b0 || if_ready !== 1'b1) begin failures++; $display("FAIL hz_resume got=%0b/%0b/%0b exp=0/0/1", id_valid, hazard_stall, if_ready); end
        sb.push_back({if_pc, if_instr});
        tick(); if_valid = 1'b0; settle();
        exp_e = sb.pop_front();
        checks++; if (id_valid !== 1'b1 || id_instr !== exp_e[31:0] || id_pc !== exp_e[63:32] ||
                      {reg_write, mem_read, mem_write, branch, alu_src} !== exp_ctrl(exp_e[31:0])) begin
            failures++; $display("FAIL hz_add_in_id got=%0b/%h/%h exp=1/%h/%h", id_valid, id_instr, id_pc, exp_e[31:0], exp_e[63:32]);
        end
        tick(); if_valid = 1'b1; if_instr = LW0; if_pc = 32'h208; settle();
        sb.push_back({if_pc, if_instr});
        tick(); if_instr = ADD; if_pc = 32'h20C; settle();
        exp_e = sb.pop_front();
        checks++; if (id_instr !== exp_e[31:0] || hazard_stall !== 1'b0 || if_ready !== 1'b1) begin
            failures++; $display("FAIL hz_x0_nostall got=%h/%0b/%0b exp=%h/0/1", id_instr, hazard_stall, if_ready, exp_e[31:0]);
        end
        sb.push_back({if_pc, if_instr});
        tick(); if_valid = 1'b0; settle();
        exp_e = sb.pop_front();
        checks++; if (id_valid !== 1'b1 || id_instr !== exp_e[31:0] || id_pc !== exp_e[63:32]) begin
            failures++; $display("FAIL hz_x0_add got=%0b/%h/%h exp=1/%h/%h", id_valid, id_instr, id_pc, exp_e[31:0], exp_e[63:32]);
        end
    endtask

    task automatic test_stall();
        tick(); if_valid = 1'b1; if_instr = SW; if_pc = 32'h300; settle();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL st_accept got=%0b exp=1", if_ready); end
        sb.push_back({if_pc, if_instr});
        tick(); ex_ready = 1'b0; if_instr = ADDI; if_pc = 32'h304; settle();
        exp_e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_instr !== exp_e[31:0] || id_pc !== exp_e[63:32] ||
                Imm_sel !== 2'b01 || {reg_write, mem_read, mem_write, branch, alu_src} !== 5'b00101) begin
                failures++;
                $display("FAIL st_hold_%0d got=%0b/%0b/%h/%h/%b exp=0/1/%h/%h/01", k, if_ready, id_valid, id_instr, id_pc, Imm_sel, exp_e[31:0], exp_e[63:32]);
            end
            if (k < 2) begin tick(); settle(); end
        end
        tick(); ex_ready = 1'b1; settle();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL st_release got=%0b exp=1", if_ready); end
        sb.push_back({if_pc, if_instr});
        tick(); if_valid = 1'b0; settle();
        exp_e = sb.pop_front();
        checks++; if (id_valid !== 1'b1 || id_instr !== exp_e[31:0] || id_pc !== exp_e[63:32]) begin
            failures++; $display("FAIL st_next got=%0b/%h/%h exp=1/%h/%h", id_valid, id_instr, id_pc, exp_e[31:0], exp_e[63:32]);
        end
    endtask

    task automatic test_flush();
        tick(); if_valid = 1'b1; if_instr = SW; if_pc = 32'h400; settle();
        tick(); flush = 1'b1; if_instr = ADDI; if_pc = 32'h404; settle();
        checks++; if (if_ready !== 1'b0 || id_instr !== SW) begin failures++; $display("FAIL fl_cycle got=%0b/%h exp=0/%h", if_ready, id_instr, SW); end
        tick(); flush = 1'b0; if_valid = 1'b0; settle();
        checks++; if (id_valid !== 1'b0 || mem_write !== 1'b0 || Imm_sel !== 2'b11) begin failures++; $display("FAIL fl_killed got=%0b/%0b/%b exp=0/0/11", id_valid, mem_write, Imm_sel); end
        tick(); settle();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fl_dropped got=%0b exp=0", id_valid); end
        tick(); if_valid = 1'b1; if_instr = LW5; if_pc = 32'h410; settle();
        tick(); if_instr = ADD; if_pc = 32'h414; flush = 1'b1; settle();
        checks++; if (hazard_stall !== 1'b0 || if_ready !== 1'b0) begin failures++; $display("FAIL fl_hz_cycle got=%0b/%0b exp=0/0", hazard_stall, if_ready); end
        tick(); flush = 1'b0; settle();
        checks++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin failures++; $display("FAIL fl_hz_run got=%0b/%0b exp=0/1", id_valid, if_ready); end
        tick(); if_valid = 1'b0; settle();
        checks++; if (id_valid !== 1'b1 || id_instr !== ADD) begin failures++; $display("FAIL fl_hz_add got=%0b/%h exp=1/%h", id_valid, id_instr, ADD); end
    endtask

    task automatic test_rst_bubble();
        tick(); if_valid = 1'b1; if_instr = LW5; if_pc = 32'h600; settle();
        tick(); if_instr = ADD; if_pc = 32'h604; settle();
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL rb_stall got=%0b exp=1", hazard_stall); end
        tick(); rst = 1'b1; if_valid = 1'b0; settle();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rb_bubble got=%0b exp=0", id_valid); end
        tick(); rst = 1'b0; settle();
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13 || id_pc !== 32'h0 || if_ready !== 1'b1) begin
            failures++; $display("FAIL rb_reset got=%0b/%h/%h/%0b exp=0/00000013/0/1", id_valid, id_instr, id_pc, if_ready);
        end
        sb.delete();
    endtask

    task automatic test_illegal();
        tick(); if_valid = 1'b1; if_instr = BAD; if_pc = 32'h500; settle();
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL il_accept got=%0b exp=1", if_ready); end
        tick(); if_instr = ADDI; if_pc = 32'h504; settle();
`ifdef DECODE_ILLEGAL_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (illegal !== 1'b1 || if_ready !== 1'b0 || id_valid !== 1'b1 || id_instr !== BAD || Imm_sel !== 2'b11 ||
                {reg_write, mem_read, mem_write, branch, alu_src} !== 5'b0) begin
                failures++; $display("FAIL il_trap_%0d got=%0b/%0b/%0b/%h/%b exp=1/0/1/%h/11", k, illegal, if_ready, id_valid, id_instr, Imm_sel, BAD);
            end
            tick(); settle();
        end
        flush = 1'b1; settle();
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL il_flush_cycle got=%0b exp=0", if_ready); end
        tick(); flush = 1'b0; if_valid = 1'b0; settle();
        checks++; if (illegal !== 1'b0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
            failures++; $display("FAIL il_cleared got=%0b/%0b/%0b exp=0/0/1", illegal, id_valid, if_ready);
        end
`else
        checks++;
        if (illegal !== 1'b0 || id_valid !== 1'b1 || id_instr !== BAD || Imm_sel !== 2'b11 || if_ready !== 1'b1 ||
            {reg_write, mem_read, mem_write, branch, alu_src} !== 5'b0) begin
            failures++; $display("FAIL il_nop got=%0b/%0b/%h/%b/%0b exp=0/1/%h/11/1", illegal, id_valid, id_instr, Imm_sel, if_ready, BAD);
        end
        tick(); if_valid = 1'b0; settle();
        checks++; if (illegal !== 1'b0 || id_valid !== 1'b1 || id_instr !== ADDI || id_pc !== 32'h504) begin
            failures++; $display("FAIL il_flow got=%0b/%0b/%h/%h exp=0/1/%h/504", illegal, id_valid, id_instr, id_pc, ADDI);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hazard();
        test_stall();
        test_flush();
        test_rst_bubble();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
